// File: rtl/instr_loader_pkg.sv
// Shared definitions for the node instruction loader: word/frame constants,
// loader FSM state encodings and a byte helper. Also imported by the bench.
package instr_loader_pkg;

  localparam int         INSTR_W    = 21;
  localparam int         BYTE_W     = 8;
  localparam int         WORD_BYTES = 3;
  localparam logic [7:0] LOAD_HDR   = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_B0    = 3'd2,
    ST_B1    = 3'd3,
    ST_B2    = 3'd4,
    ST_CSUM  = 3'd5,
    ST_ERR   = 3'd6
  } ld_state_e;

  // Top byte of a word carries only INSTR_W-16 payload bits; the rest must be zero.
  function automatic logic hi_bits_clear(input logic [BYTE_W-1:0] b);
    return (b >> (INSTR_W - (WORD_BYTES-1)*BYTE_W)) == '0;
  endfunction

endpackage

// File: rtl/instr_loader_word_asm.sv
// Byte-lane shift register: collects the low bytes of a little-endian word and
// presents the full 21-bit word plus an upper-bit check while the top byte is on the bus.
module instr_loader_word_asm
  import instr_loader_pkg::*;
#(
  parameter int LANES = WORD_BYTES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               hi_ok
);

  localparam int LOW_W = (LANES-1)*BYTE_W;

  // lanes[LANES-2] receives the newest byte, so lanes[0] ends up holding b0.
  logic [LANES-2:0][BYTE_W-1:0] lanes;

  genvar i;
  generate
    for (i = 0; i < LANES-1; i++) begin : g_lane
      if (i == LANES-2) begin : g_top
        always_ff @(posedge clk or posedge reset)
          if (reset)         lanes[i] <= '0;
          else if (shift_en) lanes[i] <= byte_in;
      end else begin : g_mid
        always_ff @(posedge clk or posedge reset)
          if (reset)         lanes[i] <= '0;
          else if (shift_en) lanes[i] <= lanes[i+1];
      end
    end
  endgenerate

  assign word  = {byte_in[INSTR_W-LOW_W-1:0], lanes};
  assign hi_ok = hi_bits_clear(byte_in);

endmodule

// File: rtl/instr_loader.sv
// Writer side of the node instruction store: parses A5/N/3N-byte frames into
// instruction-memory writes and holds the core until a full program is present.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int MAX_INSTR = 15,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [20:0]       mem_wdata,
  output logic [ADDR_W:0]   prog_len,
  output logic              core_hold,
  output logic              done,
  output logic              err
);
  import instr_loader_pkg::*;

  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [7:0]        MAX_N   = 8'(MAX_INSTR);

  ld_state_e           state;
  logic [ADDR_W-1:0]   index;
  logic [ADDR_W:0]     count;
  logic [INSTR_W-1:0]  word;
  logic                hi_ok;
  logic                hs;
  logic                last_word;

  assign hs        = in_valid & in_ready;
  assign last_word = ({1'b0, index} == (count - CNT_ONE));

  instr_loader_word_asm u_asm (
    .clk      (clk),
    .reset    (reset),
    .shift_en (hs && (state == ST_B0 || state == ST_B1)),
    .byte_in  (in_data),
    .word     (word),
    .hi_ok    (hi_ok)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of the count byte and every data byte of the frame.
  always_ff @(posedge clk or posedge reset)
    if (reset)
      csum <= '0;
    else if (hs) begin
      if (state == ST_COUNT)
        csum <= in_data;
      else if (state == ST_B0 || state == ST_B1 || state == ST_B2)
        csum <= csum ^ in_data;
    end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      prog_len  <= '0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      index     <= '0;
      count     <= '0;
    end else begin
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      if (hs) begin
        case (state)
          ST_IDLE, ST_ERR: begin
            if (in_data == LOAD_HDR) begin
              state     <= ST_COUNT;
              core_hold <= 1'b1;
              err       <= 1'b0;
            end
          end
          ST_COUNT: begin
            if (in_data == 8'd0 || in_data > MAX_N) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else begin
              count <= in_data[ADDR_W:0];
              index <= '0;
              state <= ST_B0;
            end
          end
          ST_B0: state <= ST_B1;
          ST_B1: state <= ST_B2;
          ST_B2: begin
            if (!hi_ok) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= index;
              mem_wdata <= word;
              index     <= index + IDX_ONE;
              if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                state <= ST_CSUM;
`else
                state     <= ST_IDLE;
                done      <= 1'b1;
                prog_len  <= count;
                core_hold <= 1'b0;
`endif
              end else begin
                state <= ST_B0;
              end
            end
          end
`ifdef INSTR_LOADER_CHECKSUM_EN
          ST_CSUM: begin
            if (in_data == csum) begin
              state     <= ST_IDLE;
              done      <= 1'b1;
              prog_len  <= count;
              core_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: frame parsing, count/upper-bit errors, gapped
// 15-word load, mid-frame reset and (when INSTR_LOADER_CHECKSUM_EN) checksum frames.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [20:0] mem_wdata;
  logic [4:0]  prog_len;
  logic        core_hold;
  logic        done;
  logic        err;

  instr_loader #(.MAX_INSTR(15), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .prog_len(prog_len), .core_hold(core_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write/done capture, sampled on the inactive edge.
  logic [3:0]  wr_addr[$];
  logic [20:0] wr_data[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    in_data  = b;
    in_valid = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(posedge clk);
      if (in_ready) break;
    end
    if (k == 20) chk("ready_timeout", 32'd0, 32'd1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] fb [0:63];

  // Sends fb[0..len-1]; with checksum builds a trailing XOR of fb[1..] is appended.
  task automatic send_buf(input int len, input int maxgap, input bit add_csum);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) x = x ^ fb[i];
      send_byte(fb[i]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (add_csum) send_byte(x);
`else
    if (add_csum) x = 8'd0;
`endif
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #2;
  endtask

  logic [20:0] exp_w [0:14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #13;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_core_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_prog_len",  {27'd0, prog_len},  32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_mem_wdata", {11'd0, mem_wdata}, 32'd0);
    reset = 1'b0;
    idle(2);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Basic two-word frame, with a junk byte before the header.
    clear_log();
    fb[0] = 8'h33; fb[1] = 8'hA5; fb[2] = 8'h02;
    send_byte(fb[0]);
    fb[0] = 8'hA5; fb[1] = 8'h02; fb[2] = 8'h01; fb[3] = 8'h00; fb[4] = 8'h08;
    fb[5] = 8'hFF; fb[6] = 8'h3F; fb[7] = 8'h10;
    send_buf(5, 0, 1'b0);
    chk("a_hold_mid", {31'd0, core_hold}, 32'd1);
    for (int i = 5; i < 8; i++) send_byte(fb[i]);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h02 ^ 8'h01 ^ 8'h00 ^ 8'h08 ^ 8'hFF ^ 8'h3F ^ 8'h10);
`endif
    settle();
    chk("a_nwr", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("a_addr0", {28'd0, wr_addr[0]}, 32'd0);
      chk("a_data0", {11'd0, wr_data[0]}, 32'h080001);
      chk("a_addr1", {28'd0, wr_addr[1]}, 32'd1);
      chk("a_data1", {11'd0, wr_data[1]}, 32'h103FFF);
    end
    chk("a_done",     done_cnt,               32'd1);
    chk("a_prog_len", {27'd0, prog_len},      32'd2);
    chk("a_hold",     {31'd0, core_hold},     32'd0);
    chk("a_err",      {31'd0, err},           32'd0);

    // Count 0 and count 16 are rejected.
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h00);
    settle();
    chk("c0_err",  {31'd0, err},       32'd1);
    chk("c0_hold", {31'd0, core_hold}, 32'd1);
    chk("c0_len",  {27'd0, prog_len},  32'd2);
    send_byte(8'hA5);
    chk("c16_err_clr", {31'd0, err}, 32'd0);
    send_byte(8'h10);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    settle();
    chk("c16_err",  {31'd0, err},      32'd1);
    chk("c16_len",  {27'd0, prog_len}, 32'd2);
    chk("c_nwr",    wr_addr.size(),    32'd0);
    chk("c_done",   done_cnt,          32'd0);

    // Upper bits set in third byte, then a good one-word frame recovers.
    clear_log();
    fb[0] = 8'hA5; fb[1] = 8'h01; fb[2] = 8'h11; fb[3] = 8'h22; fb[4] = 8'h20;
    send_buf(5, 0, 1'b0);
    settle();
    chk("hb_err",  {31'd0, err},       32'd1);
    chk("hb_nwr",  wr_addr.size(),     32'd0);
    chk("hb_hold", {31'd0, core_hold}, 32'd1);
    fb[0] = 8'hA5; fb[1] = 8'h01; fb[2] = 8'h34; fb[3] = 8'h12; fb[4] = 8'h05;
    send_buf(5, 0, 1'b1);
    settle();
    chk("rc_err",  {31'd0, err},       32'd0);
    chk("rc_nwr",  wr_addr.size(),     32'd1);
    if (wr_addr.size() == 1) chk("rc_data", {11'd0, wr_data[0]}, 32'h051234);
    chk("rc_len",  {27'd0, prog_len},  32'd1);
    chk("rc_hold", {31'd0, core_hold}, 32'd0);
    chk("rc_done", done_cnt,           32'd1);

    // Fifteen words with random gaps between bytes.
    clear_log();
    fb[0] = 8'hA5; fb[1] = 8'd15;
    for (int w = 0; w < 15; w++) begin
      fb[2+3*w] = 8'($urandom);
      fb[3+3*w] = 8'($urandom);
      fb[4+3*w] = 8'($urandom_range(0, 31));
      exp_w[w]  = {fb[4+3*w][4:0], fb[3+3*w], fb[2+3*w]};
    end
    send_buf(47, 5, 1'b1);
    settle();
    chk("m_nwr", wr_addr.size(), 32'd15);
    if (wr_addr.size() == 15)
      for (int w = 0; w < 15; w++) begin
        chk($sformatf("m_addr%0d", w), {28'd0, wr_addr[w]}, w);
        chk($sformatf("m_data%0d", w), {11'd0, wr_data[w]}, {11'd0, exp_w[w]});
      end
    chk("m_len",  {27'd0, prog_len},  32'd15);
    chk("m_hold", {31'd0, core_hold}, 32'd0);

    // Async reset after the fourth data byte.
    fb[0] = 8'hA5; fb[1] = 8'h02; fb[2] = 8'hAA; fb[3] = 8'hBB; fb[4] = 8'h0C; fb[5] = 8'hDD;
    send_buf(6, 0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mr_in_ready", {31'd0, in_ready},  32'd0);
    chk("mr_mem_we",   {31'd0, mem_we},    32'd0);
    chk("mr_addr",     {28'd0, mem_addr},  32'd0);
    chk("mr_wdata",    {11'd0, mem_wdata}, 32'd0);
    chk("mr_len",      {27'd0, prog_len},  32'd0);
    chk("mr_hold",     {31'd0, core_hold}, 32'd1);
    chk("mr_err",      {31'd0, err},       32'd0);
    #7;
    reset = 1'b0;
    idle(2);
    clear_log();
    fb[0] = 8'hA5; fb[1] = 8'h02; fb[2] = 8'h01; fb[3] = 8'h02; fb[4] = 8'h03;
    fb[5] = 8'h04; fb[6] = 8'h05; fb[7] = 8'h06;
    send_buf(8, 0, 1'b1);
    settle();
    chk("pr_nwr", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("pr_data0", {11'd0, wr_data[0]}, 32'h030201);
      chk("pr_data1", {11'd0, wr_data[1]}, 32'h060504);
    end
    chk("pr_len",  {27'd0, prog_len},  32'd2);
    chk("pr_hold", {31'd0, core_hold}, 32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h01);
    settle();
    chk("cs_done", done_cnt,          32'd1);
    chk("cs_len",  {27'd0, prog_len}, 32'd1);
    chk("cs_err",  {31'd0, err},      32'd0);
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h00);
    settle();
    chk("csb_err",  {31'd0, err},       32'd1);
    chk("csb_hold", {31'd0, core_hold}, 32'd1);
    chk("csb_done", done_cnt,           32'd0);
    chk("csb_len",  {27'd0, prog_len},  32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
